// File: rtl/reg_file_cmd_ctrl_pkg.sv
// rtl/reg_file_cmd_ctrl_pkg.sv - shared state encoding and command opcodes for the register file command controller
package reg_file_cmd_ctrl_pkg;

    localparam logic [7:0] C_WR_CMD = 8'hAA;
    localparam logic [7:0] C_RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

endpackage

// File: rtl/reg_file_cmd_ctrl.sv
// rtl/reg_file_cmd_ctrl.sv - decodes UART RX command frames into register file accesses and returns read data to UART TX
module reg_file_cmd_ctrl
    import reg_file_cmd_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] WR_CMD     = C_WR_CMD,
    parameter logic [DATA_WIDTH-1:0] RD_CMD     = C_RD_CMD
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_READY,
    output logic                  CMD_ERR,
    output logic                  OVERRUN
);

    state_t                r_state;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_vld;
    logic                  r_cmd_err;
    logic                  r_overrun;

    state_t                w_state_nxt;
    logic                  w_wr_en_nxt;
    logic                  w_rd_en_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wr_data_nxt;
    logic [DATA_WIDTH-1:0] w_tx_data_nxt;
    logic                  w_tx_vld_nxt;
    logic                  w_cmd_err_nxt;
    logic                  w_overrun_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_tx_vld  <= w_tx_vld_nxt;
            r_cmd_err <= w_cmd_err_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    // Strobes are registered, so each *_EXEC state raises its enable one cycle later.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_tx_data_nxt = r_tx_data;
        w_tx_vld_nxt  = r_tx_vld;
        w_cmd_err_nxt = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wr_data_nxt = RX_P_DATA;
                    w_state_nxt   = WR_EXEC;
                end
            end
            WR_EXEC: begin
                w_wr_en_nxt   = 1'b1;
                w_overrun_nxt = RX_D_VLD;
                w_state_nxt   = IDLE;
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt = RD_EXEC;
                end
            end
            RD_EXEC: begin
                w_rd_en_nxt   = 1'b1;
                w_overrun_nxt = RX_D_VLD;
                w_state_nxt   = RD_WAIT;
            end
            RD_WAIT: begin
                // While RdEn is still on the bus RdData is stale; capture the cycle after.
                w_overrun_nxt = RX_D_VLD;
                if (!r_rd_en) begin
                    w_tx_data_nxt = RdData;
                    w_tx_vld_nxt  = 1'b1;
                    w_state_nxt   = TX_SEND;
                end
            end
            TX_SEND: begin
                w_overrun_nxt = RX_D_VLD;
                if (TX_READY) begin
                    w_tx_vld_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign WrEn      = r_wr_en;
    assign RdEn      = r_rd_en;
    assign Address   = r_addr;
    assign WrData    = r_wr_data;
    assign TX_P_DATA = r_tx_data;
    assign TX_D_VLD  = r_tx_vld;
    assign CMD_ERR   = r_cmd_err;
    assign OVERRUN   = r_overrun;

endmodule

// File: doc/reg_file_cmd_ctrl.md
Name: reg_file_cmd_ctrl

Overview:
- Command controller directly upstream of the register file.
- Consumes received bytes from the UART RX path and decodes write/read command frames.
- Drives the register file's WrEn/RdEn/Address/WrData, captures RdData one cycle after a read, and hands the result to the UART TX path over a valid/ready handshake.
- Single clock domain (the register file's domain).

Parameters:
- DATA_WIDTH, 8, width of RX bytes, register data and TX data.
- ADDR_WIDTH, 3, register file address width; the low ADDR_WIDTH bits of the address byte are used.
- WR_CMD, 8'hAA, write command opcode.
- RD_CMD, 8'hBB, read command opcode.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid.
- WrEn  out  1  register file write enable.
- RdEn  out  1  register file read enable.
- Address  out  ADDR_WIDTH  register file address.
- WrData  out  DATA_WIDTH  register file write data.
- RdData  in  DATA_WIDTH  register file read data, valid the cycle after RdEn.
- TX_P_DATA  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  TX_P_DATA valid.
- TX_READY  in  1  TX accepts the byte when TX_D_VLD & TX_READY.
- CMD_ERR  out  1  one-cycle pulse on an unknown opcode.
- OVERRUN  out  1  one-cycle pulse when a byte is dropped while busy.

Behaviour:
- Reset: the clock is CLK and the reset is RST, asynchronous and active-low. While RST=0, the FSM is in IDLE and every output is 0.
- All outputs are registered. WrEn and RdEn are never high in the same cycle.
- Frame format:
  - Write: WR_CMD, ADDR, DATA.
  - Read: RD_CMD, ADDR.
- FSM states and transitions:
  - IDLE: on RX_D_VLD, if RX_P_DATA==WR_CMD go to WR_ADDR; if ==RD_CMD go to RD_ADDR; otherwise pulse CMD_ERR next cycle and stay in IDLE.
  - WR_ADDR: on RX_D_VLD, latch Address<=RX_P_DATA[ADDR_WIDTH-1:0] (upper bits discarded, no error) and go to WR_DATA.
  - WR_DATA: on RX_D_VLD, latch WrData<=RX_P_DATA and go to WR_EXEC.
  - WR_EXEC: WrEn=1 for exactly one cycle with Address/WrData stable, then go to IDLE. WrData keeps its value afterwards.
  - RD_ADDR: on RX_D_VLD, latch Address and go to RD_EXEC.
  - RD_EXEC: RdEn=1 for exactly one cycle, then go to RD_WAIT.
  - RD_WAIT: capture TX_P_DATA<=RdData, set TX_D_VLD=1, go to TX_SEND.
  - TX_SEND: hold TX_P_DATA/TX_D_VLD stable until TX_READY=1. In the accept cycle, clear TX_D_VLD next edge and go to IDLE.
- Latency:
  - Last write byte strobe to WrEn high: 2 cycles.
  - Address strobe to RdEn high: 2 cycles.
  - RdEn to TX_D_VLD: 2 cycles.
- RX_D_VLD arriving in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: the byte is dropped, OVERRUN pulses the next cycle, and the state is unaffected.
- No timeout: a partial frame waits indefinitely; only reset aborts it.
- Reset mid-frame or mid-TX: immediate return to IDLE with all outputs at 0; a pending TX byte is lost.
- TX_READY is ignored when TX_D_VLD=0.
- Back-to-back frames: a new command byte is accepted in IDLE the cycle after WR_EXEC or after the TX accept.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND);
  - the WR_CMD/RD_CMD opcode constants, shared with the host-side test models.
- No sub-module: a single FSM with its datapath registers.

Test Plan:
- Write frame AA,05,3C -> WrEn=1 for one cycle with Address=5, WrData=8'h3C, 2 cycles after the third strobe; no TX activity.
- Write AA,05,3C, then read BB,05 with a register file model -> RdEn=1 one cycle at Address=5; TX_D_VLD=1 with TX_P_DATA=8'h3C two cycles later.
- Read with TX_READY held low for 10 cycles -> TX_P_DATA/TX_D_VLD stable all 10 cycles; one accept on TX_READY=1; then IDLE.
- Opcode 8'h12 -> CMD_ERR pulses once; no WrEn/RdEn; a following AA,07,FF write succeeds to Address=7.
- RX_D_VLD during TX_SEND -> OVERRUN pulses once; TX byte unchanged; no register file access.
- RST low after AA,02 -> all outputs 0; a subsequent byte 8'h44 is decoded as an opcode (CMD_ERR), not as data.
